ysyx_23060072_mem_arbiter: RTL and testbench
============================================

Name: ysyx_23060072_mem_arbiter

Overview:
- Single-outstanding arbiter that shares one data-memory port between the instruction-fetch unit (IFU) and the load/store unit (LSU).
- Sits between the IFU/LSU and the memory bus.
- Produces the per-requester hold flags that stall the fetch stage and the LSU stage, and routes each read response back to the requester that issued it.
- Fixed LSU-over-IFU priority, with a starvation guard for the IFU and a response timeout.

Parameters:
- STARVE_LIMIT, 4: maximum number of consecutive arbitrations the IFU may lose before it is forced to win.
- TIMEOUT, 255: number of cycles in REQ+WAIT after which the transaction is aborted with an error.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- ifu_req_i  in  1  IFU read request, held until completion
- ifu_addr_i  in  32  IFU read address
- ifu_hold_o  out  1  IFU stall
- ifu_rvalid_o  out  1  IFU response strobe
- ifu_rdata_o  out  32  IFU read data
- lsu_req_i  in  1  LSU request, held until completion
- lsu_we_i  in  1  1 = store
- lsu_wmask_i  in  4  byte strobes
- lsu_addr_i  in  32  LSU address
- lsu_wdata_i  in  32  store data
- lsu_hold_o  out  1  LSU stall
- lsu_rvalid_o  out  1  LSU response/ack strobe
- lsu_rdata_o  out  32  load data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  bus write enable
- mem_wmask_o  out  4  bus byte strobes
- mem_addr_o  out  32  bus address
- mem_wdata_o  out  32  bus write data
- mem_gnt_i  in  1  bus accepts request
- mem_rvalid_i  in  1  bus response (read data or write ack)
- mem_rdata_i  in  32  bus read data
- err_o  out  1  one-cycle timeout pulse

Behaviour:
- Reset state:
  - FSM = IDLE; owner = none; starve_cnt = 0; timeout counter = 0; err_o = 0.
  - All mem_* outputs = 0; rvalid outputs = 0; rdata outputs = 0.
  - Reset mid-transaction abandons the transaction. An mem_rvalid_i that arrives later while in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - If any request is present, select a winner.
  - LSU wins over IFU, unless starve_cnt == STARVE_LIMIT, in which case the IFU wins.
  - Latch the winner's fields into the mem_* registers and record the owner, then go to REQ.
  - IFU transactions drive we = 0 and wmask = 0.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, when both requests are present and the LSU wins.
  - Clears when the IFU wins.
- REQ:
  - mem_req_o = 1 and all mem_* fields are held stable.
  - mem_gnt_i = 1 → WAIT; mem_req_o drops in WAIT.
- WAIT:
  - mem_rvalid_i is only honoured in WAIT; an rvalid in the same cycle as gnt is not expected.
  - mem_rvalid_i = 1 → owner's rvalid_o = 1 combinationally in that cycle, owner's rdata_o = mem_rdata_i, then → IDLE.
  - Stores also complete on mem_rvalid_i, which acts as the write ack; lsu_rdata_o is driven but the LSU ignores it.
- Response outputs:
  - rvalid_o and rdata_o are 0 except in the owner's completion cycle; rdata is gated to 0 otherwise.
- Hold flags:
  - x_hold_o = x_req_i && !(x_rvalid_o).
  - The requester is held from the cycle its request appears until, and not including, its completion cycle.
  - A losing requester stays held.
  - Requesters keep req and fields stable while held.
- Latency (zero-wait memory):
  - Request seen in IDLE at cycle 0, gnt at cycle 1, rvalid at cycle 2 → completion at cycle 2.
  - hold_o is high in cycles 0–1 and low in cycle 2.
- Back-to-back requests: the arbiter is in IDLE the cycle after completion and may accept a new request that same cycle.
- Timeout:
  - The counter runs while in REQ or WAIT and clears on entry to IDLE.
  - When it reaches TIMEOUT, the arbiter completes to the owner with rvalid_o = 1 and rdata_o = 0, pulses err_o for 1 cycle, drops mem_req_o, and returns to IDLE.
  - A late gnt or rvalid after the abort is ignored.
- Simultaneous events: if mem_rvalid_i arrives in the same cycle the timeout triggers, the real data wins and err_o stays 0.

Test Plan:
- IFU-only read, zero-wait bus returning 0x00000013 → ifu_hold_o high for 2 cycles; ifu_rvalid_o pulses with 0x00000013 at cycle 2; mem_we_o = 0 throughout.
- LSU store to addr 0x80000010, data 0xDEADBEEF, wmask 4'b0011, gnt delayed 3 cycles → mem fields are stable through REQ; lsu_rvalid_o pulses on the ack; ifu outputs stay 0.
- IFU and LSU both requesting continuously, STARVE_LIMIT = 4 → grant order is LSU×4, IFU, LSU×4, IFU…; the losing requester's hold_o stays high.
- Bus never asserts rvalid, TIMEOUT = 255 → lsu_rvalid_o = 1 with rdata 0 and err_o = 1 for one cycle at cycle 255 after entering REQ; FSM returns to IDLE; a later mem_rvalid_i is ignored.
- rst_n pulled low while in WAIT, then mem_rvalid_i arrives after reset release → no rvalid_o pulse; all outputs 0; a next IFU request proceeds normally.
- rvalid and timeout in the same cycle → data is delivered and err_o = 0.

Source files
------------

// File: rtl/ysyx_23060072_mem_arbiter.sv
// Single-outstanding arbiter sharing one data-memory port between the IFU and the LSU.
// LSU has fixed priority; a starvation guard and a response timeout keep the IFU moving.
module ysyx_23060072_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ifu_req_i,
    input  logic [31:0] ifu_addr_i,
    output logic        ifu_hold_o,
    output logic        ifu_rvalid_o,
    output logic [31:0] ifu_rdata_o,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_wmask_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_hold_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_wmask_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // state | meaning
    // IDLE  | no transaction; pick a winner and latch its fields
    // REQ   | mem_req_o high, waiting for mem_gnt_i
    // WAIT  | granted, waiting for mem_rvalid_i (read data or write ack)
    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IFU, OWN_LSU} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          we_q, we_d;
    logic [3:0]    wmask_q, wmask_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          busy, done, timeout, ifu_win, ifu_own, lsu_own;

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == WAIT) && mem_rvalid_i;
    // Down-counter loaded on leaving IDLE; terminal count aborts the transaction.
    assign timeout = busy && (tmr_q == '0);
    assign ifu_own = (owner_q == OWN_IFU);
    assign lsu_own = (owner_q == OWN_LSU);
    assign ifu_win = ifu_req_i && (!lsu_req_i || (starve_q == SW'(STARVE_LIMIT)));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        tmr_d    = tmr_q;
        we_d     = we_q;
        wmask_d  = wmask_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE: begin
                tmr_d = '0;
                if (ifu_req_i || lsu_req_i) begin
                    state_d = REQ;
                    tmr_d   = TW'(TIMEOUT);
                    if (ifu_win) begin
                        owner_d  = OWN_IFU;
                        starve_d = '0;
                        we_d     = 1'b0;
                        wmask_d  = '0;
                        addr_d   = ifu_addr_i;
                        wdata_d  = '0;
                    end else begin
                        owner_d = OWN_LSU;
                        // The IFU wins at the limit, so this can never overflow it.
                        if (ifu_req_i)
                            starve_d = starve_q + SW'(1);
                        we_d    = lsu_we_i;
                        wmask_d = lsu_wmask_i;
                        addr_d  = lsu_addr_i;
                        wdata_d = lsu_wdata_i;
                    end
                end
            end
            REQ, WAIT: begin
                tmr_d = tmr_q - TW'(1);
                if (done || timeout) begin
                    state_d = IDLE;
                    owner_d = OWN_NONE;
                    tmr_d   = '0;
                end else if (state_q == REQ && mem_gnt_i) begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= OWN_NONE;
            starve_q <= '0;
            tmr_q    <= '0;
            we_q     <= 1'b0;
            wmask_q  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
            tmr_q    <= tmr_d;
            we_q     <= we_d;
            wmask_q  <= wmask_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign mem_req_o   = (state_q == REQ);
    assign mem_we_o    = we_q;
    assign mem_wmask_o = wmask_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    // Real data beats a coincident timeout; an abort returns zero data.
    assign ifu_rvalid_o = (done || timeout) && ifu_own;
    assign lsu_rvalid_o = (done || timeout) && lsu_own;
    assign ifu_rdata_o  = (done && ifu_own) ? mem_rdata_i : '0;
    assign lsu_rdata_o  = (done && lsu_own) ? mem_rdata_i : '0;
    assign err_o        = timeout && !done;

    assign ifu_hold_o = ifu_req_i && !ifu_rvalid_o;
    assign lsu_hold_o = lsu_req_i && !lsu_rvalid_o;
endmodule

// File: tb/tb_ysyx_23060072_mem_arbiter.sv
// Bench for ysyx_23060072_mem_arbiter: directed vector table, corner sequences,
// and randomized traffic checked against a transaction-level arbitration model.
module tb_ysyx_23060072_mem_arbiter;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 255;
    localparam logic [31:0] IFU_ADDR = 32'h8000_0000;
    localparam logic [31:0] LSU_ADDR = 32'h8000_0010;
    localparam logic [31:0] ST_DATA  = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_i, ifu_hold_o, ifu_rvalid_o;
    logic [31:0] ifu_addr_i, ifu_rdata_o;
    logic        lsu_req_i, lsu_we_i, lsu_hold_o, lsu_rvalid_o;
    logic [3:0]  lsu_wmask_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, err_o;
    logic [3:0]  mem_wmask_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int n_vec = 0;
    int n_bad = 0;

    ysyx_23060072_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_hold_o(ifu_hold_o),
        .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_wmask_i(lsu_wmask_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_hold_o(lsu_hold_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  in;      // {ifu_req, lsu_req, lsu_we, gnt, rvalid}
        logic [31:0] rdata;
        logic [6:0]  ex;      // {mem_req, lsu_owns, we, ifu_hold, ifu_rv, lsu_hold, lsu_rv}
        logic [31:0] e_rdata;
    } vec_t;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ifu_req_i = 1'b0; ifu_addr_i = '0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_wmask_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk32({tag, " flags"}, 32'({ifu_hold_o, ifu_rvalid_o, lsu_hold_o, lsu_rvalid_o,
                                     mem_req_o, mem_we_o, mem_wmask_o, err_o}), 32'h0);
        chk32({tag, " mem_addr"}, mem_addr_o, 32'h0);
        chk32({tag, " mem_wdata"}, mem_wdata_o, 32'h0);
        chk32({tag, " ifu_rdata"}, ifu_rdata_o, 32'h0);
        chk32({tag, " lsu_rdata"}, lsu_rdata_o, 32'h0);
    endtask

    task automatic run_table();
        vec_t tbl[18];
        logic e_req, e_own, e_we, e_ih, e_irv, e_lh, e_lrv;
        tbl[0]  = '{5'b10000, 32'h0,        7'b0001000, 32'h0};
        tbl[1]  = '{5'b10010, 32'h0,        7'b1001000, 32'h0};
        tbl[2]  = '{5'b10001, 32'h0000_0013, 7'b0000100, 32'h0000_0013};
        tbl[3]  = '{5'b01100, 32'h0,        7'b0000010, 32'h0};
        tbl[4]  = '{5'b01100, 32'h0,        7'b1110010, 32'h0};
        tbl[5]  = '{5'b01100, 32'h0,        7'b1110010, 32'h0};
        tbl[6]  = '{5'b01100, 32'h0,        7'b1110010, 32'h0};
        tbl[7]  = '{5'b01110, 32'h0,        7'b1110010, 32'h0};
        tbl[8]  = '{5'b01100, 32'h0,        7'b0110010, 32'h0};
        tbl[9]  = '{5'b01101, 32'h1234_5678, 7'b0110001, 32'h1234_5678};
        tbl[10] = '{5'b00001, 32'hFFFF_FFFF, 7'b0000000, 32'h0};
        tbl[11] = '{5'b11001, 32'hFFFF_FFFF, 7'b0001010, 32'h0};
        tbl[12] = '{5'b11010, 32'h0,        7'b1101010, 32'h0};
        tbl[13] = '{5'b11001, 32'hA5A5_A5A5, 7'b0101001, 32'hA5A5_A5A5};
        tbl[14] = '{5'b10000, 32'h0,        7'b0001000, 32'h0};
        tbl[15] = '{5'b10010, 32'h0,        7'b1001000, 32'h0};
        tbl[16] = '{5'b10001, 32'h0000_0055, 7'b0000100, 32'h0000_0055};
        tbl[17] = '{5'b00000, 32'h0,        7'b0000000, 32'h0};
        ifu_addr_i = IFU_ADDR; lsu_addr_i = LSU_ADDR; lsu_wdata_i = ST_DATA; lsu_wmask_i = 4'b0011;
        for (int i = 0; i < 18; i++) begin
            {ifu_req_i, lsu_req_i, lsu_we_i, mem_gnt_i, mem_rvalid_i} = tbl[i].in;
            mem_rdata_i = tbl[i].rdata;
            @(negedge clk);
            {e_req, e_own, e_we, e_ih, e_irv, e_lh, e_lrv} = tbl[i].ex;
            chk1($sformatf("tbl%0d mem_req", i), mem_req_o, e_req);
            chk1($sformatf("tbl%0d ifu_hold", i), ifu_hold_o, e_ih);
            chk1($sformatf("tbl%0d ifu_rvalid", i), ifu_rvalid_o, e_irv);
            chk32($sformatf("tbl%0d ifu_rdata", i), ifu_rdata_o, e_irv ? tbl[i].e_rdata : 32'h0);
            chk1($sformatf("tbl%0d lsu_hold", i), lsu_hold_o, e_lh);
            chk1($sformatf("tbl%0d lsu_rvalid", i), lsu_rvalid_o, e_lrv);
            chk32($sformatf("tbl%0d lsu_rdata", i), lsu_rdata_o, e_lrv ? tbl[i].e_rdata : 32'h0);
            chk1($sformatf("tbl%0d err", i), err_o, 1'b0);
            if (e_req) begin
                chk32($sformatf("tbl%0d mem_addr", i), mem_addr_o, e_own ? LSU_ADDR : IFU_ADDR);
                chk1($sformatf("tbl%0d mem_we", i), mem_we_o, e_we);
                chk32($sformatf("tbl%0d mem_wmask", i), 32'(mem_wmask_o), e_own ? 32'h3 : 32'h0);
                if (e_own)
                    chk32($sformatf("tbl%0d mem_wdata", i), mem_wdata_o, ST_DATA);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic seq_starve();
        int  grants = 0;
        bit  exp_ifu;
        do_reset();
        ifu_addr_i = IFU_ADDR; lsu_addr_i = LSU_ADDR;
        ifu_req_i = 1'b1; lsu_req_i = 1'b1;
        mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h1111_2222;
        for (int cyc = 0; cyc < 60 && grants < 10; cyc++) begin
            @(negedge clk);
            if (mem_req_o) begin
                exp_ifu = (grants % (STARVE_LIMIT + 1)) == STARVE_LIMIT;
                chk32($sformatf("starve grant%0d owner", grants), mem_addr_o,
                      exp_ifu ? IFU_ADDR : LSU_ADDR);
                chk1($sformatf("starve grant%0d loser hold", grants),
                     exp_ifu ? lsu_hold_o : ifu_hold_o, 1'b1);
                grants++;
            end
            next_cycle();
        end
        chk32("starve grant count", grants, 32'd10);
        idle_inputs();
    endtask

    task automatic seq_timeout(input bit with_data);
        int early = 0;
        string tag = with_data ? "tmo+data" : "tmo";
        do_reset();
        lsu_req_i = 1'b1; lsu_addr_i = LSU_ADDR;
        next_cycle();
        for (int k = 0; k <= TIMEOUT; k++) begin
            mem_gnt_i    = (k == 0);
            mem_rvalid_i = with_data && (k == TIMEOUT);
            mem_rdata_i  = 32'hCAFE_F00D;
            @(negedge clk);
            if (k < TIMEOUT) begin
                if (lsu_rvalid_o || err_o || ifu_rvalid_o) early++;
            end else begin
                chk1({tag, " lsu_rvalid"}, lsu_rvalid_o, 1'b1);
                chk32({tag, " lsu_rdata"}, lsu_rdata_o, with_data ? 32'hCAFE_F00D : 32'h0);
                chk1({tag, " err"}, err_o, !with_data);
                chk1({tag, " lsu_hold"}, lsu_hold_o, 1'b0);
                chk1({tag, " ifu_rvalid"}, ifu_rvalid_o, 1'b0);
            end
            next_cycle();
        end
        chk32({tag, " early events"}, early, 32'd0);
        lsu_req_i = 1'b0; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
        @(negedge clk);
        chk1({tag, " late lsu_rvalid"}, lsu_rvalid_o, 1'b0);
        chk32({tag, " late lsu_rdata"}, lsu_rdata_o, 32'h0);
        chk1({tag, " late err"}, err_o, 1'b0);
        chk1({tag, " late mem_req"}, mem_req_o, 1'b0);
        next_cycle();
        idle_inputs();
    endtask

    task automatic seq_reset_wait();
        do_reset();
        ifu_req_i = 1'b1; ifu_addr_i = IFU_ADDR;
        next_cycle();
        mem_gnt_i = 1'b1;
        next_cycle();
        mem_gnt_i = 1'b0;
        @(negedge clk);
        chk1("rstw held in WAIT", ifu_hold_o, 1'b1);
        next_cycle();
        rst_n = 1'b0; ifu_req_i = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        check_all_zero("rstw late rvalid");
        next_cycle();
        @(negedge clk);
        chk1("rstw late rvalid 2", ifu_rvalid_o, 1'b0);
        next_cycle();
        mem_rvalid_i = 1'b0; ifu_req_i = 1'b1; ifu_addr_i = 32'h8000_0100;
        @(negedge clk);
        chk1("rstw new idle mem_req", mem_req_o, 1'b0);
        chk1("rstw new hold", ifu_hold_o, 1'b1);
        next_cycle();
        mem_gnt_i = 1'b1;
        @(negedge clk);
        chk1("rstw new mem_req", mem_req_o, 1'b1);
        chk32("rstw new mem_addr", mem_addr_o, 32'h8000_0100);
        next_cycle();
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0000_0093;
        @(negedge clk);
        chk1("rstw new rvalid", ifu_rvalid_o, 1'b1);
        chk32("rstw new rdata", ifu_rdata_o, 32'h0000_0093);
        chk1("rstw new hold done", ifu_hold_o, 1'b0);
        next_cycle();
        idle_inputs();
    endtask

    // Transaction-level model: at most one transaction in flight, winner chosen by
    // LSU priority unless the IFU has lost STARVE_LIMIT contested rounds in a row.
    task automatic run_random(input int ncyc);
        bit busy = 0, granted = 0, own_lsu = 0, ifu_done = 0, lsu_done = 0, comp;
        int starve = 0, gdly = 0, rdly = 0;
        logic        x_we, e_irv, e_lrv;
        logic [3:0]  x_wmask;
        logic [31:0] x_addr, x_wdata;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            if (ifu_done) begin ifu_req_i = 1'b0; ifu_done = 0; end
            if (lsu_done) begin lsu_req_i = 1'b0; lsu_done = 0; end
            if (!ifu_req_i && $urandom_range(0, 2) == 0) begin
                ifu_req_i = 1'b1; ifu_addr_i = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_i && $urandom_range(0, 1) == 0) begin
                lsu_req_i = 1'b1; lsu_we_i = 1'($urandom_range(0, 1));
                lsu_wmask_i = 4'($urandom); lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
            end
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = $urandom;
            if (busy && !granted) begin
                if (gdly == 0) mem_gnt_i = 1'b1; else gdly--;
            end else if (busy) begin
                if (rdly == 0) mem_rvalid_i = 1'b1; else rdly--;
            end else begin
                mem_rvalid_i = ($urandom_range(0, 7) == 0);
            end
            @(negedge clk);
            comp  = busy && granted && mem_rvalid_i;
            e_irv = comp && !own_lsu;
            e_lrv = comp && own_lsu;
            chk1("rnd mem_req", mem_req_o, busy && !granted);
            if (busy && !granted) begin
                chk32("rnd mem_addr", mem_addr_o, x_addr);
                chk1("rnd mem_we", mem_we_o, x_we);
                chk32("rnd mem_wmask", 32'(mem_wmask_o), 32'(x_wmask));
                if (own_lsu) chk32("rnd mem_wdata", mem_wdata_o, x_wdata);
            end
            chk1("rnd ifu_rvalid", ifu_rvalid_o, e_irv);
            chk32("rnd ifu_rdata", ifu_rdata_o, e_irv ? mem_rdata_i : 32'h0);
            chk1("rnd lsu_rvalid", lsu_rvalid_o, e_lrv);
            chk32("rnd lsu_rdata", lsu_rdata_o, e_lrv ? mem_rdata_i : 32'h0);
            chk1("rnd ifu_hold", ifu_hold_o, ifu_req_i && !e_irv);
            chk1("rnd lsu_hold", lsu_hold_o, lsu_req_i && !e_lrv);
            chk1("rnd err", err_o, 1'b0);
            if (!busy) begin
                if (ifu_req_i || lsu_req_i) begin
                    own_lsu = lsu_req_i && !(ifu_req_i && starve == STARVE_LIMIT);
                    if (!own_lsu) starve = 0;
                    else if (ifu_req_i && starve < STARVE_LIMIT) starve++;
                    x_addr  = own_lsu ? lsu_addr_i : ifu_addr_i;
                    x_we    = own_lsu ? lsu_we_i : 1'b0;
                    x_wmask = own_lsu ? lsu_wmask_i : 4'h0;
                    x_wdata = lsu_wdata_i;
                    busy = 1; granted = 0; gdly = $urandom_range(0, 3);
                end
            end else if (!granted) begin
                if (mem_gnt_i) begin granted = 1; rdly = $urandom_range(0, 3); end
            end else if (comp) begin
                busy = 0;
                if (own_lsu) lsu_done = 1; else ifu_done = 1;
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        do_reset();
        @(negedge clk);
        check_all_zero("reset");
        next_cycle();
        run_table();
        seq_starve();
        seq_timeout(1'b0);
        seq_timeout(1'b1);
        seq_reset_wait();
        run_random(2000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
